noc_credit_injector: RTL and testbench

//  Downstream of the VC-table packetizer: takes its flits over valid/ready and injects them into the
//  NoC router input port, which uses per-VC credit flow control (no ready). Buffers flits in a small

---
 rtl/noc_flit_pkg.sv | 26 ++
 rtl/noc_credit_injector_fifo.sv | 50 +++++
 rtl/noc_credit_injector.sv | 98 +++++++++
 tb/tb_noc_credit_injector.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
// Flit field positions and credit counter sizing shared by the NoC credit injector.
package noc_flit_pkg;

    function automatic int flit_valid_bit(input int width);
        return width - 1;
    endfunction

    function automatic int flit_head_bit(input int width);
        return width - 2;
    endfunction

    function automatic int flit_tail_bit(input int width);
        return width - 3;
    endfunction

    // LSB of the VC id field that sits directly below the tail bit.
    function automatic int flit_vc_lsb(input int width, input int vc_width);
        return width - 3 - vc_width;
    endfunction

    // A counter must represent every value from 0 to depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_credit_injector_fifo.sv
// Synchronous flit FIFO with a combinational head output and a separate fill counter.
module flit_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/noc_credit_injector.sv
// Buffers packetizer flits and injects them into a credit-flow-controlled router port in order.
module noc_credit_injector
    import noc_flit_pkg::*;
#(
    parameter int WIDTH            = 36,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int FIFO_DEPTH       = 4,
    parameter int VC_BUF_DEPTH     = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [WIDTH-1:0]                data_in,
    input  logic                            valid_in,
    output logic                            ready_out,
    output logic [WIDTH-1:0]                flit_out,
    output logic                            valid_out,
    input  logic [2**VC_ADDRESS_WIDTH-1:0]  credit_in,
    output logic                            credit_err,
    output logic [$clog2(FIFO_DEPTH):0]     occupancy
);

    localparam int NUM_VC    = 2 ** VC_ADDRESS_WIDTH;
    localparam int CW        = credit_width(VC_BUF_DEPTH);
    localparam int VALID_BIT = flit_valid_bit(WIDTH);
    localparam int VC_LSB    = flit_vc_lsb(WIDTH, VC_ADDRESS_WIDTH);
    localparam logic [CW-1:0] MAX_CREDITS = CW'(VC_BUF_DEPTH);

    // The flit must carry control bits, the VC id and the router address.
    if (WIDTH < 3 + VC_ADDRESS_WIDTH + ADDRESS_WIDTH) begin : g_width_check
        $error("noc_credit_injector: WIDTH too small for flit fields");
    end

    logic [WIDTH-1:0]            head_flit;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        push;
    logic                        pop;
    logic [VC_ADDRESS_WIDTH-1:0] head_vc;
    logic [NUM_VC-1:0]           issue_vc;
    logic [CW-1:0]               credits [NUM_VC];

    // Invalid flits are handshaken but never stored.
    assign ready_out = !fifo_full;
    assign push      = valid_in && ready_out && data_in[VALID_BIT];
    assign head_vc   = head_flit[VC_LSB +: VC_ADDRESS_WIDTH];
    // A credit arriving this cycle already counts toward the head's eligibility.
    assign pop       = !fifo_empty && ((credits[head_vc] != '0) || credit_in[head_vc]);

    flit_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (data_in),
        .pop       (pop),
        .head      (head_flit),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    // NOTE: always_comb assigns a default before any conditional write so no latch is inferred.
    always_comb begin
        issue_vc = '0;
        if (pop) issue_vc[head_vc] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) credits[v] <= MAX_CREDITS;
            credit_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (credit_in[v] && !issue_vc[v]) begin
                    if (credits[v] == MAX_CREDITS) credit_err <= 1'b1;
                    else                           credits[v] <= credits[v] + 1'b1;
                end else if (issue_vc[v] && !credit_in[v]) begin
                    credits[v] <= credits[v] - 1'b1;
                end
            end
        end
    end

    // flit_out holds the last issued flit while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop;
            if (pop) flit_out <= head_flit;
        end
    end

endmodule

// File: tb/tb_noc_credit_injector.sv
// Directed bench for noc_credit_injector with a queue-based reference model checked every cycle.
module tb_noc_credit_injector;

    localparam int W       = 36;
    localparam int FD      = 4;
    localparam int CREDITS = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  data_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [W-1:0]  flit_out;
    logic          valid_out;
    logic [1:0]    credit_in = '0;
    logic          credit_err;
    logic [2:0]    occupancy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    noc_credit_injector #(
        .WIDTH            (W),
        .ADDRESS_WIDTH    (4),
        .VC_ADDRESS_WIDTH (1),
        .FIFO_DEPTH       (FD),
        .VC_BUF_DEPTH     (CREDITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .flit_out   (flit_out),
        .valid_out  (valid_out),
        .credit_in  (credit_in),
        .credit_err (credit_err),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [W-1:0] mk(input bit h, input bit t, input bit vc, input int unsigned pay);
        return {1'b1, h, t, vc, pay[31:0]};
    endfunction

    // Reference model: a queue of stored flits and one integer credit count per VC.
    logic [W-1:0] m_q[$];
    int           m_cred[2] = '{CREDITS, CREDITS};
    logic         m_valid = 1'b0;
    logic [W-1:0] m_flit = '0;
    logic         m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit take;
        bit send;
        int hv;
        int delta;
        if (!rst_n) begin
            m_q.delete();
            m_cred  = '{CREDITS, CREDITS};
            m_valid = 1'b0;
            m_flit  = '0;
            m_err   = 1'b0;
        end else begin
            take = valid_in && (m_q.size() < FD) && data_in[W-1];
            send = 1'b0;
            hv   = 0;
            if (m_q.size() > 0) begin
                hv   = int'(m_q[0][W-4]);
                send = (m_cred[hv] > 0) || credit_in[hv];
            end
            for (int v = 0; v < 2; v++) begin
                delta = int'(credit_in[v]) - ((send && hv == v) ? 1 : 0);
                if (delta > 0 && m_cred[v] == CREDITS) m_err = 1'b1;
                else m_cred[v] += delta;
            end
            m_valid = send;
            if (send) m_flit = m_q.pop_front();
            if (take) m_q.push_back(data_in);
        end
    end

    // Per-cycle compare against the model, plus a log of every issued flit.
    logic [W-1:0] log_q[$];
    int           log_cyc[$];

    always @(negedge clk) begin
        check("valid_out", valid_out, m_valid);
        check("flit_out", flit_out, m_flit);
        check("ready_out", ready_out, m_q.size() < FD);
        check("occupancy", occupancy, m_q.size());
        check("credit_err", credit_err, m_err);
        if (rst_n && valid_out) begin
            log_q.push_back(flit_out);
            log_cyc.push_back(cycle);
        end
    end

    // Upstream source: presents up_q[0] and pops it once the handshake completes.
    logic [W-1:0] up_q[$];
    bit           drv_ready = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            valid_in  = 1'b0;
            drv_ready = 1'b0;
        end else begin
            if (valid_in && drv_ready) up_q.delete(0);
            valid_in  = (up_q.size() > 0);
            data_in   = valid_in ? up_q[0] : '0;
            drv_ready = ready_out;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        credit_in = '0;
        up_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic pulse(input int v);
        credit_in[v] = 1'b1;
        tick(1);
        credit_in[v] = 1'b0;
    endtask

    task automatic feed(input int n, input bit vc, input int unsigned pay);
        for (int i = 0; i < n; i++) up_q.push_back(mk(i == 0, i == n - 1, vc, pay + i));
    endtask

    initial begin
        int base;
        int t0;
        int n;
        logic [W-1:0] bad;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t0;
        int n;
        logic [W-1:0] bad;
        #2;
        do_reset();
        check("reset_ready", ready_out, 1);
        check("reset_occupancy", occupancy, 0);

        // 1: three VC0 flits back-to-back, then probe that 7 credits remain.
        base = log_q.size();
        t0   = cycle;
        feed(3, 1'b0, 100);
        tick(8);
        check("t1_count", log_q.size() - base, 3);
        for (int k = 0; k < 3; k++) begin
            check("t1_cycle", log_cyc[base + k] - t0, 2 + k);
            check("t1_order", log_q[base + k], mk(k == 0, k == 2, 1'b0, 100 + k));
        end
        base = log_q.size();
        feed(8, 1'b0, 200);
        tick(20);
        check("t1_credits_left", log_q.size() - base, 7);
        check("t1_stall_occ", occupancy, 1);

        // 2: 16 VC1 flits, no credit returns: 10 issue, FIFO fills, 2 wait upstream.
        do_reset();
        base = log_q.size();
        feed(16, 1'b1, 300);
        tick(30);
        check("t2_issued", log_q.size() - base, 10);
        check("t2_ready", ready_out, 0);
        check("t2_occ", occupancy, 4);
        check("t2_upstream", up_q.size(), 2);
        pulse(1);
        tick(3);
        check("t2_one_more", log_q.size() - base, 11);
        for (int k = 0; k < 11; k++)
            check("t2_order", log_q[base + k], mk(k == 0, 1'b0, 1'b1, 300 + k));

        // 3: VC0 head with zero credits blocks a VC1 flit behind it.
        do_reset();
        feed(10, 1'b0, 400);
        tick(16);
        base = log_q.size();
        up_q.push_back(mk(1'b1, 1'b0, 1'b0, 500));
        up_q.push_back(mk(1'b1, 1'b1, 1'b1, 501));
        tick(6);
        check("t3_hol_none", log_q.size() - base, 0);
        check("t3_hol_occ", occupancy, 2);
        pulse(0);
        tick(3);
        check("t3_released", log_q.size() - base, 2);
        check("t3_first", log_q[base], mk(1'b1, 1'b0, 1'b0, 500));
        check("t3_second", log_q[base + 1], mk(1'b1, 1'b1, 1'b1, 501));

        // 4: overflow on a full VC, then a simultaneous issue and return at 5 credits.
        do_reset();
        pulse(1);
        tick(1);
        check("t4_err_set", credit_err, 1);
        base = log_q.size();
        feed(11, 1'b1, 600);
        tick(20);
        check("t4_vc1_saturated", log_q.size() - base, 10);
        pulse(1);
        tick(3);
        feed(5, 1'b0, 700);
        tick(10);
        up_q.push_back(mk(1'b1, 1'b1, 1'b0, 750));
        n = 0;
        while (occupancy == 0 && n < 10) begin
            tick(1);
            n++;
        end
        check("t4_wait_push", occupancy, 1);
        pulse(0);
        tick(2);
        base = log_q.size();
        feed(6, 1'b0, 800);
        tick(15);
        check("t4_vc0_kept_5", log_q.size() - base, 5);
        check("t4_err_sticky", credit_err, 1);

        // 5: a flit with its valid bit clear is accepted and dropped.
        do_reset();
        base = log_q.size();
        bad  = 36'h7_0000_00AB;
        up_q.push_back(bad);
        check("t5_ready", ready_out, 1);
        tick(6);
        check("t5_not_issued", log_q.size() - base, 0);
        check("t5_occ", occupancy, 0);
        check("t5_accepted", up_q.size(), 0);

        // 6: asynchronous reset with three flits of a partial packet stalled in the FIFO.
        do_reset();
        feed(10, 1'b0, 900);
        tick(16);
        up_q.push_back(mk(1'b1, 1'b0, 1'b0, 950));
        up_q.push_back(mk(1'b0, 1'b0, 1'b0, 951));
        up_q.push_back(mk(1'b0, 1'b0, 1'b0, 952));
        tick(6);
        check("t6_occ_before", occupancy, 3);
        check("t6_flit_before", flit_out, mk(1'b0, 1'b1, 1'b0, 909));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", valid_out, 0);
        check("t6_async_flit", flit_out, 0);
        check("t6_async_occ", occupancy, 0);
        check("t6_async_ready", ready_out, 1);
        up_q.delete();
        credit_in = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        base = log_q.size();
        feed(11, 1'b0, 1000);
        tick(20);
        check("t6_credits_restored", log_q.size() - base, 10);
        check("t6_stall_occ", occupancy, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
